// File: rtl/ram_ctrl.sv
// Request/response front end for an external single-port RAM with combinational read.
// It has a 2-entry response FIFO and a sequencer that zeroes the whole RAM.
module ram_ctrl #(
    parameter int DataWidth = 32,
    parameter int NPos      = 1024,
    parameter int NPosWidth = $clog2(NPos)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [NPosWidth-1:0] req_addr_i,
    input  logic [DataWidth-1:0] req_wdata_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 rsp_we_o,
    output logic [DataWidth-1:0] rsp_rdata_o,
    input  logic                 clr_start_i,
    output logic                 busy_o,
    output logic [NPosWidth-1:0] ram_a_o,
    output logic                 ram_we_o,
    output logic [DataWidth-1:0] ram_wd_o,
    input  logic [DataWidth-1:0] ram_rd_i
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [NPosWidth-1:0] LAST_ADDR = NPosWidth'(NPos - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [NPosWidth-1:0] r_clr_cnt;
    logic [NPosWidth-1:0] w_clr_cnt_next;

    logic [DataWidth-1:0] r_fifo_data [2];
    logic                 r_fifo_we   [2];
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [1:0]           r_count;

    logic                 w_fifo_room;
    logic                 w_req_ready;
    logic                 w_push;
    logic                 w_pop;
    logic [NPosWidth-1:0] w_ram_a;
    logic                 w_ram_we;
    logic [DataWidth-1:0] w_ram_wd;
    logic                 w_busy;

    // A full FIFO still has room when its head leaves in the same cycle.
    assign w_fifo_room = (r_count != 2'd2) || (rsp_valid_o && rsp_ready_i);
    assign w_push      = w_req_ready && req_valid_i;
    assign w_pop       = (r_count != 2'd0) && rsp_ready_i;

    // Next-state, clear counter and RAM port steering.
    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        w_req_ready    = 1'b0;
        w_ram_a        = req_addr_i;
        w_ram_we       = 1'b0;
        w_ram_wd       = req_wdata_i;
        w_busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = !rst_i && !clr_start_i && w_fifo_room;
                w_ram_we    = w_req_ready && req_valid_i && req_we_i;
                if (clr_start_i) begin
                    w_state_next   = ST_CLEAR;
                    w_clr_cnt_next = '0;
                end else begin
                    w_state_next   = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                w_busy   = 1'b1;
                w_ram_a  = r_clr_cnt;
                w_ram_we = !rst_i;
                w_ram_wd = '0;
                // Stopping on the last index keeps non power-of-two depths in range.
                if (r_clr_cnt == LAST_ADDR) begin
                    w_state_next   = ST_IDLE;
                    w_clr_cnt_next = '0;
                end else begin
                    w_state_next   = ST_CLEAR;
                    w_clr_cnt_next = r_clr_cnt + NPosWidth'(1);
                end
            end
            default: begin
                w_state_next   = ST_IDLE;
                w_clr_cnt_next = '0;
            end
        endcase
    end

    // State and clear counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
        end
    end

    // Response FIFO storage, pointers and occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fifo_data <= '{default: '0};
            r_fifo_we   <= '{default: 1'b0};
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_we[r_wr_ptr]   <= req_we_i;
                r_fifo_data[r_wr_ptr] <= req_we_i ? req_wdata_i : ram_rd_i;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

    assign req_ready_o = w_req_ready;
    assign rsp_valid_o = (r_count != 2'd0);
    assign rsp_we_o    = r_fifo_we[r_rd_ptr];
    assign rsp_rdata_o = r_fifo_data[r_rd_ptr];
    assign busy_o      = w_busy;
    assign ram_a_o     = w_ram_a;
    assign ram_we_o    = w_ram_we;
    assign ram_wd_o    = w_ram_wd;

endmodule

// File: doc/ram_ctrl.md
RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 Parameters SHALL be: DataWidth, default 32, word width; NPos, default 1024, number of RAM words; NPosWidth, default $clog2(NPos), address width.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 req_valid_i  input  1  request present.
REQ-005 req_ready_o  output  1  request accepted this cycle when high together with req_valid_i.
REQ-006 req_we_i  input  1  1 = write, 0 = read.
REQ-007 req_addr_i  input  NPosWidth  word address.
REQ-008 req_wdata_i  input  DataWidth  write data.
REQ-009 rsp_valid_o  output  1  response available.
REQ-010 rsp_ready_i  input  1  consumer takes response when high with rsp_valid_o.
REQ-011 rsp_we_o  output  1  response is a write acknowledge (1) or read data (0).
REQ-012 rsp_rdata_o  output  DataWidth  read data, or the written data for a write acknowledge.
REQ-013 clr_start_i  input  1  single-cycle request to zero the whole RAM.
REQ-014 busy_o  output  1  clear in progress.
REQ-015 ram_a_o  output  NPosWidth  RAM address, to ram a_i.
REQ-016 ram_we_o  output  1  RAM write enable, to ram we_i.
REQ-017 ram_wd_o  output  DataWidth  RAM write data, to ram wd_i.
REQ-018 ram_rd_i  input  DataWidth  RAM combinational read data, from ram rd_o.

Function
REQ-019 The controller SHALL have FSM states IDLE and CLEAR.
REQ-020 In IDLE, req_ready_o SHALL be 1 when clr_start_i=0 and either the response FIFO holds fewer than 2 entries or it holds 2 entries with rsp_valid_o=1 and rsp_ready_i=1.
REQ-021 In IDLE, ram_a_o SHALL equal req_addr_i and ram_wd_o SHALL equal req_wdata_i.
REQ-022 ram_we_o SHALL be 1 in IDLE only on an accepted write, that is req_valid_i, req_ready_o and req_we_i all high.
REQ-023 On an accepted read, the FIFO SHALL capture {we=0, data=ram_rd_i} in that same cycle.
REQ-024 On an accepted write, the FIFO SHALL capture {we=1, data=req_wdata_i}.
REQ-025 Response latency SHALL be exactly 1 cycle: rsp_valid_o rises the cycle after acceptance when the FIFO was empty.
REQ-026 The response FIFO SHALL have 2 entries, preserve order, and support a push and a pop in the same cycle; rsp_valid_o = (count != 0).
REQ-027 Sustained throughput SHALL be 1 request per cycle while rsp_ready_i=1.
REQ-028 A read following a write to the same address on the next cycle SHALL return the newly written data.
REQ-029 IDLE -> CLEAR SHALL occur on clr_start_i=1; in that cycle no request is accepted and the clear counter loads 0.
REQ-030 In CLEAR, ram_a_o SHALL equal the counter, ram_we_o SHALL be 1 and ram_wd_o SHALL be 0; the counter increments by 1 each cycle.
REQ-031 In CLEAR, req_ready_o SHALL be 0 and busy_o SHALL be 1.
REQ-032 CLEAR -> IDLE SHALL occur in the cycle the counter equals NPos-1, after that write; CLEAR SHALL last exactly NPos cycles.
REQ-033 clr_start_i SHALL be ignored while in CLEAR.
REQ-034 FIFO entries pending at clear start SHALL still drain normally during CLEAR.
REQ-035 When NPos is not a power of two, no RAM address >= NPos SHALL ever be driven during CLEAR.

Reset
REQ-036 While rst_i=1, the block SHALL be in IDLE with the FIFO empty and the clear counter at 0.
REQ-037 While rst_i=1, the outputs SHALL be: rsp_valid_o=0, busy_o=0, ram_we_o=0, rsp_we_o=0, rsp_rdata_o=0.
REQ-038 Reset asserted during CLEAR SHALL abort the clear immediately; the RAM is left partially cleared and no further clear writes occur.

Verification
REQ-039 The bench SHALL cover: write addr 5 data 0xA5A5A5A5, then read addr 5 next cycle -> write ack with rdata 0xA5A5A5A5, then read response 0xA5A5A5A5 one cycle later.
REQ-040 The bench SHALL cover: rsp_ready_i=0 with back-to-back reads -> 2 accepted, req_ready_o=0 on the 3rd; raising rsp_ready_i -> 3rd accepted that same cycle, responses in order.
REQ-041 The bench SHALL cover: streaming 100 reads with rsp_ready_i=1 -> 100 responses in 101 cycles, no stall.
REQ-042 The bench SHALL cover: clr_start_i with NPos=1024 -> busy_o high for exactly 1024 cycles and all words read back as 0.
REQ-043 The bench SHALL cover: clr_start_i and req_valid_i in the same cycle -> request not accepted, clear starts, request accepted in the first cycle after busy_o falls.
REQ-044 The bench SHALL cover: rst_i pulse at clear counter value 10 -> words 0-9 read back as 0, word 10 onward unchanged, busy_o=0 after reset.
